// File: rtl/ddr5_phy_crc_insert.sv
// DDR5 write-path CRC transmitter: forwards 8-beat write bursts with one register
// stage and, when write CRC is enabled, appends a per-nibble CRC-8 beat as beat 9.
module ddr5_phy_crc_insert #(
   parameter int pDRAM_SIZE = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    crc_en_i,
   input  logic                    wrdata_valid_i,
   input  logic [2*pDRAM_SIZE-1:0] wrdata_i,
   output logic                    wrdata_ready_o,
   output logic                    wrdata_valid_o,
   output logic [2*pDRAM_SIZE-1:0] wrdata_o,
   output logic                    crc_beat_o
);

   localparam int W   = 2 * pDRAM_SIZE;
   localparam int NIB = pDRAM_SIZE / 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_CRC
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 en_q, en_d;
   logic [NIB*8-1:0]     crc_q, crc_d;
   logic                 valid_q, valid_d;
   logic [W-1:0]         data_q, data_d;
   logic                 crcb_q, crcb_d;

   logic                 accept;
   logic [NIB*8-1:0]     crc_base;
   logic [NIB*8-1:0]     crc_next;
   logic [W-1:0]         crc_word;

   // Serial CRC-8 (x^8+x^2+x+1) over one beat of a nibble: UI 2k DQ0..3, then UI 2k+1 DQ0..3.
   function automatic logic [7:0] crc8_step(input logic [7:0] c_in,
                                            input logic [3:0] ui_a,
                                            input logic [3:0] ui_b);
      logic [7:0] c;
      logic [7:0] bits;
      logic       fb;
      c    = c_in;
      bits = {ui_b, ui_a};
      for (int unsigned i = 0; i < 8; i++) begin
         fb = c[7] ^ bits[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   assign wrdata_ready_o = (state_q != ST_CRC);
   assign accept         = wrdata_valid_i && wrdata_ready_o;

   // The first beat of a burst starts from a zero CRC rather than the stale register.
   always_comb begin
      crc_base = (state_q == ST_IDLE) ? '0 : crc_q;
      crc_next = '0;
      crc_word = '0;
      for (int unsigned n = 0; n < NIB; n++) begin
         crc_next[8*n +: 8] = crc8_step(crc_base[8*n +: 8], wrdata_i[4*n +: 4],
                                        wrdata_i[pDRAM_SIZE + 4*n +: 4]);
         crc_word[4*n +: 4]              = crc_q[8*n +: 4];
         crc_word[pDRAM_SIZE + 4*n +: 4] = crc_q[8*n + 4 +: 4];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      crc_d   = crc_q;
      valid_d = 1'b0;
      data_d  = data_q;
      crcb_d  = 1'b0;

      if (accept) begin
         valid_d = 1'b1;
         data_d  = wrdata_i;
         crc_d   = crc_next;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_DATA;
               cnt_d   = 4'd1;
               en_d    = crc_en_i;
            end
         end
         ST_DATA: begin
            if (accept) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  state_d = en_q ? ST_CRC : ST_IDLE;
               end
            end
         end
         ST_CRC: begin
            valid_d = 1'b1;
            data_d  = crc_word;
            crcb_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         crc_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         crcb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         crc_q   <= crc_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         crcb_q  <= crcb_d;
      end
   end

   assign wrdata_valid_o = valid_q;
   assign wrdata_o       = data_q;
   assign crc_beat_o     = crcb_q;

endmodule

// File: tb/tb_ddr5_phy_crc_insert.sv
// Bench for ddr5_phy_crc_insert: literal x4 bursts plus an x16 instance checked every
// cycle against a burst-level model whose CRC is computed by polynomial long division.
module tb_ddr5_phy_crc_insert;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic chk_on = 1'b0;

   // x4 instance
   logic        a_en = 1'b0, a_valid = 1'b0;
   logic [7:0]  a_data = '0;
   logic        a_ready, a_valid_o, a_crcb;
   logic [7:0]  a_data_o;

   // x16 instance
   logic        x_en = 1'b0, x_valid = 1'b0;
   logic [31:0] x_data = '0;
   logic        x_ready, x_valid_o, x_crcb;
   logic [31:0] x_data_o;

   ddr5_phy_crc_insert #(.pDRAM_SIZE(4)) u_x4 (
      .clk_i(clk), .rst_i(rst), .crc_en_i(a_en), .wrdata_valid_i(a_valid),
      .wrdata_i(a_data), .wrdata_ready_o(a_ready), .wrdata_valid_o(a_valid_o),
      .wrdata_o(a_data_o), .crc_beat_o(a_crcb));

   ddr5_phy_crc_insert #(.pDRAM_SIZE(16)) u_x16 (
      .clk_i(clk), .rst_i(rst), .crc_en_i(x_en), .wrdata_valid_i(x_valid),
      .wrdata_i(x_data), .wrdata_ready_o(x_ready), .wrdata_valid_o(x_valid_o),
      .wrdata_o(x_data_o), .crc_beat_o(x_crcb));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference CRC: message per nibble is 64 bits, first-fed bit is the MSB; remainder of M*x^8 mod g.
   function automatic logic [31:0] ref_crc(input logic [31:0] bts [8]);
      logic [31:0] res;
      logic [63:0] m;
      logic [71:0] r;
      res = '0;
      for (int n = 0; n < 4; n++) begin
         m = '0;
         for (int u = 0; u < 16; u++)
            for (int d = 0; d < 4; d++)
               m = {m[62:0], bts[u/2][(u%2)*16 + 4*n + d]};
         r = {m, 8'h00};
         for (int i = 71; i >= 8; i--)
            if (r[i]) r = r ^ (72'h107 << (i - 8));
         res[4*n +: 4]      = r[3:0];
         res[16 + 4*n +: 4] = r[7:4];
      end
      return res;
   endfunction

   // Burst-level model of the x16 instance: outputs expected after each clock edge.
   logic        m_ready = 1'b1, m_valid = 1'b0, m_crcb = 1'b0, m_pend = 1'b0, m_en = 1'b0;
   logic [31:0] m_data = '0;
   logic [31:0] mburst [8];
   int          mcnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ready <= 1'b1; m_valid <= 1'b0; m_crcb <= 1'b0; m_data <= '0;
         m_pend  <= 1'b0; mcnt <= 0;
      end else if (m_pend) begin
         m_valid <= 1'b1; m_crcb <= 1'b1; m_data <= ref_crc(mburst);
         m_pend  <= 1'b0; m_ready <= 1'b1;
      end else begin
         m_valid <= 1'b0; m_crcb <= 1'b0;
         if (m_ready && x_valid) begin
            if (mcnt == 0) m_en <= x_en;
            mburst[mcnt] <= x_data;
            m_valid <= 1'b1;
            m_data  <= x_data;
            if (mcnt == 7) begin
               mcnt <= 0;
               if ((mcnt == 0) ? x_en : m_en) begin
                  m_pend <= 1'b1; m_ready <= 1'b0;
               end
            end else begin
               mcnt <= mcnt + 1;
            end
         end
      end
   end

   int n_out = 0, n_crc = 0, n_rdy_low = 0;
   logic [31:0] last_crc = '0;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("x16_valid", {31'd0, x_valid_o}, {31'd0, m_valid});
         chk("x16_data", x_data_o, m_data);
         chk("x16_crc_beat", {31'd0, x_crcb}, {31'd0, m_crcb});
         chk("x16_ready", {31'd0, x_ready}, {31'd0, m_ready});
         if (!rst) begin
            if (x_valid_o) n_out++;
            if (x_crcb) begin n_crc++; last_crc = x_data_o; end
            if (!x_ready) n_rdy_low++;
         end
      end
   end

   logic [31:0] bb [8];

   task automatic idle(input int n);
      x_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_beat(input logic [31:0] d);
      logic acc;
      int   guard;
      x_valid = 1'b1;
      x_data  = d;
      guard   = 0;
      do begin
         acc = x_ready;
         @(posedge clk); #1;
         guard++;
      end while (!acc && guard < 10);
      chk("x16_accept_timeout", {31'd0, acc}, 32'd1);
   endtask

   task automatic send_burst(input logic [7:0] gaps, input int tog_at);
      for (int k = 0; k < 8; k++) begin
         if (gaps[k]) begin x_valid = 1'b0; @(posedge clk); #1; end
         if (k == tog_at) x_en = ~x_en;
         send_beat(bb[k]);
      end
   endtask

   task automatic rand_burst();
      for (int k = 0; k < 8; k++) bb[k] = $urandom;
   endtask

   task automatic run_x4(input logic [7:0] last, input logic [7:0] exp_crc);
      a_en = 1'b1; a_valid = 1'b1; a_data = 8'h00;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (k < 7) a_data = (k == 6) ? last : 8'h00;
         else a_valid = 1'b0;
         chk("x4_beat_valid", {31'd0, a_valid_o}, 32'd1);
         chk("x4_beat_data", {24'd0, a_data_o}, {24'd0, (k == 7) ? last : 8'h00});
         chk("x4_beat_crcflag", {31'd0, a_crcb}, 32'd0);
         chk("x4_ready", {31'd0, a_ready}, (k == 7) ? 32'd0 : 32'd1);
      end
      @(posedge clk); #1;
      chk("x4_crc_valid", {31'd0, a_valid_o}, 32'd1);
      chk("x4_crc_data", {24'd0, a_data_o}, {24'd0, exp_crc});
      chk("x4_crc_flag", {31'd0, a_crcb}, 32'd1);
      chk("x4_ready_after", {31'd0, a_ready}, 32'd1);
      @(posedge clk); #1;
      chk("x4_idle_valid", {31'd0, a_valid_o}, 32'd0);
      chk("x4_idle_hold", {24'd0, a_data_o}, {24'd0, exp_crc});
      chk("x4_idle_flag", {31'd0, a_crcb}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int s_out, s_crc, s_low;
      logic [31:0] crc_ref1;
      #1 rst = 1'b1;
      #1 chk_on = 1'b1;
      @(negedge clk);
      chk("x4_reset_ready", {31'd0, a_ready}, 32'd1);
      chk("x4_reset_valid", {31'd0, a_valid_o}, 32'd0);
      chk("x4_reset_data", {24'd0, a_data_o}, 32'd0);
      chk("x4_reset_flag", {31'd0, a_crcb}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // model pin: each nibble's message is 1 -> CRC 0x07 per nibble
      for (int k = 0; k < 8; k++) bb[k] = (k == 7) ? 32'h8888_0000 : 32'h0;
      chk("ref_pin_7777", ref_crc(bb), 32'h0000_7777);
      for (int k = 0; k < 8; k++) bb[k] = 32'h0;
      chk("ref_pin_zero", ref_crc(bb), 32'h0000_0000);

      run_x4(8'h00, 8'h00);
      run_x4(8'h80, 8'h07);

      // 20 back-to-back random bursts with CRC
      x_en = 1'b1;
      s_out = n_out; s_crc = n_crc; s_low = n_rdy_low;
      for (int b = 0; b < 20; b++) begin rand_burst(); send_burst(8'h00, -1); end
      idle(4);
      chk("b2b_out_beats", n_out - s_out, 180);
      chk("b2b_crc_beats", n_crc - s_crc, 20);
      chk("b2b_bubbles", n_rdy_low - s_low, 20);

      // CRC disabled: pass-through, no bubble
      x_en = 1'b0;
      s_out = n_out; s_crc = n_crc; s_low = n_rdy_low;
      for (int b = 0; b < 3; b++) begin rand_burst(); send_burst(8'h00, -1); end
      idle(3);
      chk("nocrc_out_beats", n_out - s_out, 24);
      chk("nocrc_crc_beats", n_crc - s_crc, 0);
      chk("nocrc_bubbles", n_rdy_low - s_low, 0);

      // enable toggled mid-burst and valid gaps must not change the CRC
      rand_burst();
      crc_ref1 = ref_crc(bb);
      x_en = 1'b1;
      send_burst(8'h00, -1);
      idle(3);
      chk("gapfree_crc", last_crc, crc_ref1);
      last_crc = '0;
      s_crc = n_crc;
      send_burst(8'b0010_0100, 4);
      idle(3);
      chk("gapped_crc_emitted", n_crc - s_crc, 1);
      chk("gapped_crc", last_crc, crc_ref1);
      x_en = 1'b1;

      // reset in the middle of a burst
      rand_burst();
      s_crc = n_crc;
      for (int k = 0; k < 5; k++) send_beat(bb[k]);
      x_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_valid", {31'd0, x_valid_o}, 32'd0);
      chk("rst_data", x_data_o, 32'd0);
      chk("rst_flag", {31'd0, x_crcb}, 32'd0);
      chk("rst_ready", {31'd0, x_ready}, 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      idle(12);
      chk("rst_no_crc", n_crc - s_crc, 0);
      for (int k = 0; k < 8; k++) bb[k] = (k == 7) ? 32'h8888_0000 : 32'h0;
      send_burst(8'h00, -1);
      idle(3);
      chk("post_rst_crc", last_crc, 32'h0000_7777);
      chk("post_rst_crc_count", n_crc - s_crc, 1);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
